gf_op_seq: RTL and testbench
============================

GF_OP_SEQ -- requirements
Module: gf_op_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width m; legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: request valid.
REQ-005 SHALL have port in_ready, output, 1 bit: sequencer can accept a request.
REQ-006 SHALL have port op, input, 2 bits: 00 ADD, 01 MUL (carry-less, unreduced), 10 SQR_RED, 11 MUL_RED.
REQ-007 SHALL have port carry_option, input, 1 bit: ADD only; 1 = carry add, 0 = XOR.
REQ-008 SHALL have ports a and b, input, DATA_WIDTH bits each: operands; b ignored for SQR_RED.
REQ-009 SHALL have port polyn_grade, input, clog2(DATA_WIDTH)+1 bits: reduction polynomial degree k.
REQ-010 SHALL have port polyn_red, input, DATA_WIDTH+1 bits: primitive polynomial including the x^k term.
REQ-011 SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port result, output, 2*DATA_WIDTH bits: operation result.
REQ-014 SHALL have port carry_out, output, 1 bit: ADD carry.
REQ-015 SHALL have port err, output, 1 bit: illegal grade flag.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 SHALL use one shared carry-less datapath instance for every operation, driven only from registered operands.
REQ-018 SHALL implement FSM states IDLE, EXEC, RED and DONE.
REQ-019 SHALL assert in_ready only in IDLE; acceptance occurs on in_valid && in_ready at a clock edge.
REQ-020 SHALL, on acceptance, register op, carry_option, a, b, polyn_grade and polyn_red, then go IDLE->EXEC; inputs are don't-care afterwards.
REQ-021 SHALL, in EXEC, drive the datapath in sum mode (ADD), multiply mode (MUL, MUL_RED) or square mode (SQR_RED), register the 2m-bit product, and go to DONE for ADD/MUL or to RED for reduced ops.
REQ-022 SHALL, in RED, drive reduction mode with the registered product, k and polyn_red, register the m-bit remainder, and go to DONE.
REQ-023 SHALL hold out_valid high in DONE with result, carry_out and err stable until out_valid && out_ready, then return to IDLE.
REQ-024 SHALL give latency from acceptance edge to out_valid high of 2 edges for ADD/MUL and 3 edges for SQR_RED/MUL_RED.
REQ-025 SHALL format result as: ADD = {zeros, m-bit sum}; MUL = full 2m-bit carry-less product; reduced ops = {zeros, remainder of degree < k}.
REQ-026 SHALL drive carry_out as the carry add carry for ADD with carry_option=1, and 0 otherwise.
REQ-027 SHALL, for a reduced op with k<2 or k>DATA_WIDTH, skip RED, go EXEC->DONE with result=0 and err=1; err=0 in every other case.
REQ-028 SHALL hold out_valid and the result unchanged for any number of cycles while out_ready is low.
REQ-029 SHALL ignore in_valid outside IDLE; no request is queued or dropped silently, because in_ready is low then.

Reset
REQ-030 SHALL, while rst_n is low, force state IDLE and in_ready=1 (once released), out_valid=0, busy=0, result=0, carry_out=0, err=0, and clear all operand registers.
REQ-031 SHALL, on reset asserted mid-operation (EXEC/RED/DONE), abandon the operation with no out_valid pulse; the next request after release behaves normally.

Configuration
REQ-032 SHALL, with macro GF_OP_SEQ_BACK_TO_BACK_EN defined, also assert in_ready in DONE when out_ready is high, so result drain and new acceptance occur on the same edge (DONE->EXEC) with no IDLE bubble.
REQ-033 SHALL, without GF_OP_SEQ_BACK_TO_BACK_EN, assert in_ready only in IDLE, giving at least one idle cycle between operations.

Verification (DATA_WIDTH=8)
REQ-034 SHALL cover ADD a=0xFF b=0x01 carry_option=1 -> result 0x0000, carry_out=1, out_valid 2 edges after accept; carry_option=0 -> 0x00FE, carry_out=0.
REQ-035 SHALL cover MUL a=0x03 b=0x03 -> result 0x0005; a=0xFF b=0xFF -> 0x5555.
REQ-036 SHALL cover MUL_RED a=0x53 b=0xCA polyn_red=0x11B k=8 -> result 0x0001, err=0, 3-edge latency; SQR_RED a=0x80 -> 0x009A.
REQ-037 SHALL cover MUL_RED with k=1 -> result 0, err=1, latency 2 edges.
REQ-038 SHALL cover out_ready held low 5 cycles -> out_valid and result stable, in_ready low; then back-to-back requests with and without the macro -> 0 versus at least 1 idle cycle between results.
REQ-039 SHALL cover rst_n pulsed low during RED -> all outputs at reset values, no out_valid; a following ADD completes correctly.

Source files
------------

// File: rtl/gf_op_seq.sv
// gf_op_seq: sequenced GF(2)-polynomial operation unit.
// Runs ADD (carry or XOR), carry-less MUL, squaring with reduction and
// multiplication with reduction on one shared, mode-selected datapath.
// Optional build macro: GF_OP_SEQ_BACK_TO_BACK_EN lets a new request be
// accepted on the same edge that drains a finished result (DONE->EXEC).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request, in_ready high
// EXEC  | datapath runs sum/multiply/square on the captured operands
// RED   | datapath reduces the captured product modulo polyn_red
// DONE  | result presented with out_valid, held until out_ready
module gf_op_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  op,
  input  logic                        carry_option,
  input  logic [DATA_WIDTH-1:0]       a,
  input  logic [DATA_WIDTH-1:0]       b,
  input  logic [$clog2(DATA_WIDTH):0] polyn_grade,
  input  logic [DATA_WIDTH:0]         polyn_red,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*DATA_WIDTH-1:0]     result,
  output logic                        carry_out,
  output logic                        err,
  output logic                        busy
);

  localparam int DW = DATA_WIDTH;
  localparam int GW = $clog2(DATA_WIDTH) + 1;

`ifdef GF_OP_SEQ_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_MUL    = 2'b01;
  localparam logic [1:0] OP_SQR    = 2'b10;
  localparam logic [1:0] OP_MULRED = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, RED, DONE} state_t;
  typedef enum logic [1:0] {DP_SUM, DP_MUL, DP_SQR, DP_RED} dp_mode_t;

  state_t            state;
  logic [1:0]        op_q;
  logic              co_q;
  logic [DW-1:0]     a_q;
  logic [DW-1:0]     b_q;
  logic [GW-1:0]     grade_q;
  logic [DW:0]       poly_q;
  logic [2*DW-1:0]   prod_q;

  dp_mode_t          dp_mode;
  logic [DW-1:0]     dp_y;
  logic [DW:0]       sum_ext;
  logic [2*DW-1:0]   clmul;
  logic [2*DW-1:0]   poly_ext;
  logic [2*DW-1:0]   red_acc;
  logic [2*DW-1:0]   dp_out;
  logic              dp_carry;

  logic              accept;
  logic              reduced_op;
  logic              grade_bad;

  // In DONE with back-to-back enabled, a drain and a new accept share one edge.
  assign in_ready   = (state == IDLE) || (B2B && (state == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign reduced_op = op_q[1];
  assign grade_bad  = (int'(grade_q) < 2) || (int'(grade_q) > DW);

  // Select the datapath mode from the current state and the captured opcode.
  always_comb begin
    dp_mode = DP_SUM;
    if (state == RED)
      dp_mode = DP_RED;
    else if ((op_q == OP_MUL) || (op_q == OP_MULRED))
      dp_mode = DP_MUL;
    else if (op_q == OP_SQR)
      dp_mode = DP_SQR;
  end

  // Shared datapath: sum, carry-less multiply/square, and polynomial reduction.
  always_comb begin
    // Squaring is a multiply of the operand with itself; b is ignored.
    dp_y     = (dp_mode == DP_SQR) ? a_q : b_q;
    sum_ext  = {1'b0, a_q} + {1'b0, dp_y};

    clmul = '0;
    for (int i = 0; i < DW; i++) begin
      if (dp_y[i])
        clmul = clmul ^ ({{DW{1'b0}}, a_q} << i);
    end

    // Long division over GF(2): clear every bit at or above degree k, top down.
    poly_ext = {{(DW-1){1'b0}}, poly_q};
    red_acc  = prod_q;
    for (int i = 2*DW-1; i >= 0; i--) begin
      if ((i >= int'(grade_q)) && red_acc[i])
        red_acc = red_acc ^ (poly_ext << (i - int'(grade_q)));
    end

    dp_out   = '0;
    dp_carry = 1'b0;
    case (dp_mode)
      DP_SUM: begin
        dp_out   = {{DW{1'b0}}, (co_q ? sum_ext[DW-1:0] : (a_q ^ dp_y))};
        dp_carry = co_q & sum_ext[DW];
      end
      DP_MUL, DP_SQR: dp_out = clmul;
      DP_RED:         dp_out = {{DW{1'b0}}, red_acc[DW-1:0]};
      default:        dp_out = '0;
    endcase
  end

  // Capture the request; the datapath only ever sees these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ADD;
      co_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      grade_q <= '0;
      poly_q  <= '0;
    end else if (accept) begin
      op_q    <= op;
      co_q    <= carry_option;
      a_q     <= a;
      b_q     <= b;
      grade_q <= polyn_grade;
      poly_q  <= polyn_red;
    end
  end

  // Operation sequencer with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prod_q    <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid)
            state <= EXEC;
        end
        EXEC: begin
          if (reduced_op && grade_bad) begin
            // An unusable degree skips reduction and reports an error instead.
            result    <= '0;
            carry_out <= 1'b0;
            err       <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (reduced_op) begin
            prod_q <= dp_out;
            state  <= RED;
          end else begin
            prod_q    <= dp_out;
            result    <= dp_out;
            carry_out <= dp_carry;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        RED: begin
          result    <= dp_out;
          carry_out <= 1'b0;
          err       <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (B2B && in_valid)
              state <= EXEC;
            else
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_op_seq.sv
// tb_gf_op_seq: directed scoreboard bench for gf_op_seq at DATA_WIDTH=8.
module tb_gf_op_seq;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = 2'b00;
  logic          carry_option = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [3:0]    polyn_grade = '0;
  logic [DW:0]   polyn_red = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*DW-1:0] result;
  logic          carry_out;
  logic          err;
  logic          busy;

  gf_op_seq #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .carry_option(carry_option), .a(a), .b(b),
    .polyn_grade(polyn_grade), .polyn_red(polyn_red),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_carry"}, carry_out, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Push the expectation, drive one request, measure latency, compare, drain.
  task automatic send(input string tag, input logic [1:0] o, input logic co,
                      input logic [7:0] x, input logic [7:0] y,
                      input logic [3:0] k, input logic [8:0] p,
                      input logic [15:0] er, input logic ec, input logic ee,
                      input int elat, input int stall);
    exp_t e;
    int n;
    int lat;
    e.res = er; e.c = ec; e.e = ee; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    op = o; carry_option = co; a = x; b = y; polyn_grade = k; polyn_red = p;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk({tag, "_accept_timeout"}, in_ready, 1);
      in_valid = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
    carry_option = 1'($urandom); polyn_grade = 4'($urandom); polyn_red = 9'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_carry"}, carry_out, e.c);
    chk({tag, "_err"}, err, e.e);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_result"}, result, e.res);
      chk({tag, "_stall_in_ready"}, in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int n;
    int idle;
    int res_cnt;
    bit seen;

    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;

    send("add_carry",  2'b00, 1'b1, 8'hFF, 8'h01, 4'd8, 9'h11B, 16'h0000, 1'b1, 1'b0, 2, 0);
    send("add_xor",    2'b00, 1'b0, 8'hFF, 8'h01, 4'd8, 9'h11B, 16'h00FE, 1'b0, 1'b0, 2, 0);
    send("add_plain",  2'b00, 1'b1, 8'h12, 8'h34, 4'd8, 9'h11B, 16'h0046, 1'b0, 1'b0, 2, 0);
    send("mul_3x3",    2'b01, 1'b0, 8'h03, 8'h03, 4'd8, 9'h11B, 16'h0005, 1'b0, 1'b0, 2, 0);
    send("mul_ffxff",  2'b01, 1'b1, 8'hFF, 8'hFF, 4'd8, 9'h11B, 16'h5555, 1'b0, 1'b0, 2, 5);
    send("mulred_aes", 2'b11, 1'b0, 8'h53, 8'hCA, 4'd8, 9'h11B, 16'h0001, 1'b0, 1'b0, 3, 0);
    send("sqrred_80",  2'b10, 1'b0, 8'h80, 8'h5A, 4'd8, 9'h11B, 16'h009A, 1'b0, 1'b0, 3, 0);
    send("mulred_x8",  2'b11, 1'b1, 8'h02, 8'h80, 4'd8, 9'h11B, 16'h001B, 1'b0, 1'b0, 3, 0);
    send("mulred_k4",  2'b11, 1'b0, 8'h08, 8'h02, 4'd4, 9'h013, 16'h0003, 1'b0, 1'b0, 3, 0);
    send("mulred_k1",  2'b11, 1'b0, 8'h53, 8'hCA, 4'd1, 9'h11B, 16'h0000, 1'b0, 1'b1, 2, 0);
    send("sqrred_k9",  2'b10, 1'b0, 8'h53, 8'h00, 4'd9, 9'h11B, 16'h0000, 1'b0, 1'b1, 2, 0);

    // Reset pulse while the reduction step is in flight.
    @(negedge clk);
    op = 2'b11; carry_option = 1'b0; a = 8'h53; b = 8'hCA;
    polyn_grade = 4'd8; polyn_red = 9'h11B; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_mid_no_valid", out_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send("add_after_rst", 2'b00, 1'b1, 8'h10, 8'h20, 4'd8, 9'h11B, 16'h0030, 1'b0, 1'b0, 2, 0);

    // Continuous requests with the consumer always ready.
    @(negedge clk);
    op = 2'b00; carry_option = 1'b1; a = 8'h01; b = 8'h02;
    polyn_grade = 4'd8; polyn_red = 9'h11B;
    in_valid = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    idle = 0;
    res_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_valid && in_ready) begin
        e.res = 16'h0003; e.c = 1'b0; e.e = 1'b0; e.lat = 0;
        sb.push_back(e);
      end
      if (seen && !busy) idle++;
      if (out_valid && sb.size() > 0) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk("b2b_result", result, e.res);
        res_cnt++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      if (out_valid && sb.size() > 0) begin
        e = sb.pop_front();
        chk("b2b_tail_result", result, e.res);
        res_cnt++;
      end
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    chk("b2b_settled", busy, 0);
    chk("b2b_count_ok", (res_cnt >= 3), 1);
`ifdef GF_OP_SEQ_BACK_TO_BACK_EN
    chk("b2b_idle_cycles", idle, 0);
`else
    chk("b2b_idle_gap_ok", (idle >= 1), 1);
`endif
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
